// File: rtl/ras_ckpt_ctrl_pkg.sv
// Shared types for the return-address-stack speculation controller.
`ifndef XLEN
`define XLEN 32
`endif

package ras_ckpt_ctrl_pkg;
  localparam int RAS_STACK_SIZE = 32;
  localparam int RAS_CKPT_DEPTH = 8;
  localparam int RAS_PTR_W      = $clog2(RAS_STACK_SIZE);
  localparam int RAS_TAG_W      = $clog2(RAS_CKPT_DEPTH);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_PTR_W:0]   count;
    logic [`XLEN-1:0]     top;
  } ras_ckpt_t;

  typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} ctrl_state_e;
endpackage

// File: rtl/ras_ckpt_fifo.sv
// Circular checkpoint table: up to two allocations and two retires per cycle,
// plus truncation back to a mispredicted tag.
module ras_ckpt_fifo
  import ras_ckpt_ctrl_pkg::*;
#(
  parameter  int DEPTH = RAS_CKPT_DEPTH,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       alloc_cnt,
  input  ras_ckpt_t        alloc_data,
  input  logic [1:0]       retire_cnt,
  input  logic             trunc_en,
  input  logic [TAG_W-1:0] trunc_tag,
  input  logic [TAG_W-1:0] rd_tag,
  output ras_ckpt_t        rd_data,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   used
);
  ras_ckpt_t        mem [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] head_nxt;

  assign head_nxt = head + TAG_W'(retire_cnt);
  assign rd_data  = mem[rd_tag];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      used <= '0;
    end else begin
      head <= head_nxt;
      if (trunc_en) begin
        tail <= trunc_tag + TAG_W'(1);
        // Inclusive distance head..tag, so a full table truncated at its
        // newest entry stays full instead of aliasing to empty.
        used <= {1'b0, TAG_W'(trunc_tag - head_nxt)} + (TAG_W+1)'(1);
      end else begin
        tail <= tail + TAG_W'(alloc_cnt);
        used <= used - (TAG_W+1)'(retire_cnt) + (TAG_W+1)'(alloc_cnt);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_cnt != 2'd0) mem[tail] <= alloc_data;
    if (alloc_cnt == 2'd2) mem[tail + TAG_W'(1)] <= alloc_data;
  end

  a_retire_legal: assert property (@(posedge clock) disable iff (reset)
    (retire_cnt != 2'd3) && ((TAG_W+1)'(retire_cnt) <= used));
endmodule

// File: rtl/ras_ckpt_ctrl.sv
// Speculative RAS pointer/count owner with per-branch checkpoints and
// one-cycle top-entry repair after a mispredict.
module ras_ckpt_ctrl
  import ras_ckpt_ctrl_pkg::*;
#(
  parameter  int STACK_SIZE = RAS_STACK_SIZE,
  parameter  int CKPT_DEPTH = RAS_CKPT_DEPTH,
  localparam int PTR_W      = $clog2(STACK_SIZE),
  localparam int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             fetch_valid,
  input  logic [1:0]             fetch_call,
  input  logic [1:0]             fetch_return,
  input  logic [1:0]             fetch_branch,
  input  logic [1:0][`XLEN-1:0]  fetch_PC,
  output logic                   fetch_stall,
  output logic [1:0][TAG_W-1:0]  ckpt_tag,
  output logic [PTR_W-1:0]       ras_rd_idx,
  input  logic [`XLEN-1:0]       ras_rd_data,
  output logic                   ras_wr_en,
  output logic [PTR_W-1:0]       ras_wr_idx,
  output logic [`XLEN-1:0]       ras_wr_data,
  output logic                   return_valid,
  output logic [`XLEN-1:0]       return_target,
  input  logic [1:0]             retire_cnt,
  input  logic                   mispredict,
  input  logic [TAG_W-1:0]       mispredict_tag
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(STACK_SIZE);

  ctrl_state_e      state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  logic [`XLEN-1:0] saved_top;

  logic             xfer0, proc1, br0, br1, is_call, is_ret, accept;
  logic [1:0]       n_br;
  logic [`XLEN-1:0] xfer_pc;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   used;
  ras_ckpt_t        alloc_data, rest;

  // A call/return in slot0 ends the bundle, so slot1 is dropped.
  assign xfer0 = fetch_valid[0] & (fetch_call[0] | fetch_return[0]);
  assign proc1 = fetch_valid[1] & ~xfer0;
  assign br0   = fetch_valid[0] & fetch_branch[0];
  assign br1   = proc1 & fetch_branch[1];
  assign n_br  = {1'b0, br0} + {1'b0, br1};

  assign fetch_stall = mispredict | (state == RECOVER) |
                       ((TAG_W+1)'(n_br) > ((TAG_W+1)'(CKPT_DEPTH) - used));
  assign accept      = ~fetch_stall;

  always_comb begin
    is_call = 1'b0;
    is_ret  = 1'b0;
    xfer_pc = fetch_PC[0];
    if (xfer0) begin
      is_call = fetch_call[0];
      is_ret  = fetch_return[0] & ~fetch_call[0];
    end else if (proc1) begin
      is_call = fetch_call[1];
      is_ret  = fetch_return[1] & ~fetch_call[1];
      xfer_pc = fetch_PC[1];
    end
  end

  assign ras_rd_idx    = ptr - PTR_W'(1);
  assign ckpt_tag[0]   = (accept & br0) ? tail : '0;
  assign ckpt_tag[1]   = (accept & br1) ? tail + TAG_W'(br0) : '0;
  assign return_valid  = accept & is_ret & (count != '0);
  assign return_target = (accept & is_ret) ? ras_rd_data : '0;

  // Branch slots always precede any call/return, so both take the pre-cycle state.
  assign alloc_data = '{ptr: ptr, count: count, top: ras_rd_data};

  always_comb begin
    ras_wr_en   = 1'b0;
    ras_wr_idx  = '0;
    ras_wr_data = '0;
    if (state == RECOVER) begin
      // A fresh mispredict supersedes the pending repair.
      if (!mispredict && count != '0) begin
        ras_wr_en   = 1'b1;
        ras_wr_idx  = ptr - PTR_W'(1);
        ras_wr_data = saved_top;
      end
    end else if (accept && is_call) begin
      ras_wr_en   = 1'b1;
      ras_wr_idx  = ptr;
      ras_wr_data = xfer_pc + `XLEN'(4);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= NORMAL;
      ptr       <= '0;
      count     <= '0;
      saved_top <= '0;
    end else if (mispredict) begin
      state     <= RECOVER;
      ptr       <= rest.ptr;
      count     <= rest.count;
      saved_top <= rest.top;
    end else if (state == RECOVER) begin
      state <= NORMAL;
    end else if (accept) begin
      if (is_call) begin
        ptr   <= ptr + PTR_W'(1);
        count <= (count == FULL) ? count : count + (PTR_W+1)'(1);
      end else if (is_ret) begin
        ptr   <= ptr - PTR_W'(1);
        count <= (count == '0) ? count : count - (PTR_W+1)'(1);
      end
    end
  end

  ras_ckpt_fifo #(.DEPTH(CKPT_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .alloc_cnt  (accept ? n_br : 2'd0),
    .alloc_data (alloc_data),
    .retire_cnt (retire_cnt),
    .trunc_en   (mispredict),
    .trunc_tag  (mispredict_tag),
    .rd_tag     (mispredict_tag),
    .rd_data    (rest),
    .tail       (tail),
    .used       (used)
  );
endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Random + directed bench for ras_ckpt_ctrl against an integer-level model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_ras_ckpt_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] fetch_valid, fetch_call, fetch_return, fetch_branch;
  logic [1:0][31:0] fetch_PC;
  logic fetch_stall;
  logic [1:0][2:0] ckpt_tag;
  logic [4:0] ras_rd_idx, ras_wr_idx;
  logic [31:0] ras_rd_data, ras_wr_data, return_target;
  logic ras_wr_en, return_valid, mispredict;
  logic [1:0] retire_cnt;
  logic [2:0] mispredict_tag;

  ras_ckpt_ctrl dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_call(fetch_call), .fetch_return(fetch_return),
    .fetch_branch(fetch_branch), .fetch_PC(fetch_PC), .fetch_stall(fetch_stall),
    .ckpt_tag(ckpt_tag), .ras_rd_idx(ras_rd_idx), .ras_rd_data(ras_rd_data),
    .ras_wr_en(ras_wr_en), .ras_wr_idx(ras_wr_idx), .ras_wr_data(ras_wr_data),
    .return_valid(return_valid), .return_target(return_target),
    .retire_cnt(retire_cnt), .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );

  always #5 clock = ~clock;

  // External stack array seen by the controller.
  logic [31:0] stk [32];
  assign ras_rd_data = stk[ras_rd_idx];
  always @(posedge clock) if (ras_wr_en) stk[ras_wr_idx] <= ras_wr_data;

  int n_chk = 0, n_pass = 0;

  // Model state: plain integers and arrays.
  int m_ptr, m_count, m_head, m_used;
  bit m_rec;
  logic [31:0] m_saved;
  int ck_ptr [8], ck_cnt [8];
  logic [31:0] ck_top [8];

  bit e_stall, e_wen, e_rv, s_call, s_ret, s_b0, s_b1;
  int e_widx, e_ridx, e_t0, e_t1;
  logic [31:0] e_wdata, e_rt, s_pc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    m_ptr = 0; m_count = 0; m_head = 0; m_used = 0; m_rec = 0; m_saved = 0;
  endtask

  task automatic model_eval();
    bit p0, p1, x0;
    int nb, tail;
    p0 = fetch_valid[0];
    x0 = p0 && (fetch_call[0] || fetch_return[0]);
    p1 = fetch_valid[1] && !x0;
    s_b0 = p0 && fetch_branch[0];
    s_b1 = p1 && fetch_branch[1];
    nb = int'(s_b0) + int'(s_b1);
    s_call = 0; s_ret = 0; s_pc = 0;
    if (x0) begin
      s_call = fetch_call[0]; s_ret = fetch_return[0]; s_pc = fetch_PC[0];
    end else if (p1 && (fetch_call[1] || fetch_return[1])) begin
      s_call = fetch_call[1]; s_ret = fetch_return[1]; s_pc = fetch_PC[1];
    end
    e_stall = mispredict || m_rec || (nb > 8 - m_used);
    e_ridx = (m_ptr + 31) % 32;
    e_wen = 0; e_widx = 0; e_wdata = 0;
    if (m_rec) begin
      if (!mispredict && m_count != 0) begin e_wen = 1; e_widx = e_ridx; e_wdata = m_saved; end
    end else if (!e_stall && s_call) begin
      e_wen = 1; e_widx = m_ptr; e_wdata = s_pc + 32'd4;
    end
    e_rv = !e_stall && s_ret && m_count > 0;
    e_rt = (!e_stall && s_ret) ? stk[e_ridx] : 32'd0;
    tail = (m_head + m_used) % 8;
    e_t0 = (!e_stall && s_b0) ? tail : 0;
    e_t1 = (!e_stall && s_b1) ? (tail + int'(s_b0)) % 8 : 0;
  endtask

  task automatic model_update();
    int nh, t;
    if (reset) return;
    nh = (m_head + int'(retire_cnt)) % 8;
    if (mispredict) begin
      t = mispredict_tag;
      m_ptr = ck_ptr[t]; m_count = ck_cnt[t]; m_saved = ck_top[t]; m_rec = 1;
      m_used = ((t - nh + 8) % 8) + 1;
    end else begin
      if (m_rec) m_rec = 0;
      else if (!e_stall) begin
        t = (m_head + m_used) % 8;
        if (s_b0) begin ck_ptr[t] = m_ptr; ck_cnt[t] = m_count; ck_top[t] = stk[e_ridx]; t = (t + 1) % 8; end
        if (s_b1) begin ck_ptr[t] = m_ptr; ck_cnt[t] = m_count; ck_top[t] = stk[e_ridx]; end
        m_used += int'(s_b0) + int'(s_b1);
        if (s_call) begin
          m_ptr = (m_ptr + 1) % 32; if (m_count < 32) m_count++;
        end else if (s_ret) begin
          m_ptr = (m_ptr + 31) % 32; if (m_count > 0) m_count--;
        end
      end
      m_used -= int'(retire_cnt);
    end
    m_head = nh;
  endtask

  task automatic compare_all();
    chk("stall", fetch_stall, e_stall);
    chk("rd_idx", ras_rd_idx, e_ridx);
    chk("wr_en", ras_wr_en, e_wen);
    chk("wr_idx", ras_wr_idx, e_widx);
    chk("wr_data", ras_wr_data, e_wdata);
    chk("ret_valid", return_valid, e_rv);
    chk("ret_target", return_target, e_rt);
    chk("tag0", ckpt_tag[0], e_t0);
    chk("tag1", ckpt_tag[1], e_t1);
  endtask

  // Drive one bundle at the falling edge, then check against the model.
  task automatic setin(input logic [1:0] v, c, r, b, input logic [31:0] pc0, pc1,
                       input logic [1:0] ret, input logic mis, input logic [2:0] tag);
    fetch_valid = v; fetch_call = c; fetch_return = r; fetch_branch = b;
    fetch_PC[0] = pc0; fetch_PC[1] = pc1;
    retire_cnt = ret; mispredict = mis; mispredict_tag = tag;
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic [1:0] ret);
    setin(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, ret, 1'b0, 3'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    idle(2'd0);
    chk("rst_rd_idx", ras_rd_idx, 31);
    chk("rst_stall", fetch_stall, 0);
    chk("rst_wr_en", ras_wr_en, 0);
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, off, rmax;
    logic [1:0] v, c, r, b, ret;
    logic mis;
    logic [2:0] tag;
    for (int i = 0; i < 32; i++) stk[i] = $urandom;

    // Call then matching return.
    do_reset();
    setin(2'b01, 2'b01, 2'b00, 2'b00, 32'h100, 32'h0, 2'd0, 1'b0, 3'd0);
    chk("call_wr_en", ras_wr_en, 1); chk("call_wr_idx", ras_wr_idx, 0); chk("call_wr_data", ras_wr_data, 32'h104);
    step();
    setin(2'b01, 2'b00, 2'b01, 2'b00, 32'h300, 32'h0, 2'd0, 1'b0, 3'd0);
    chk("ret_valid_lit", return_valid, 1); chk("ret_target_lit", return_target, 32'h104);
    step();
    idle(2'd0); chk("ptr_back_0", ras_rd_idx, 31); step();

    // Overflow wrap and underflow.
    for (int i = 0; i < 33; i++) begin
      setin(2'b01, 2'b01, 2'b00, 2'b00, 32'h1000 + 32'(i * 4), 32'h0, 2'd0, 1'b0, 3'd0); step();
    end
    idle(2'd0); chk("wrap_ptr1", ras_rd_idx, 0); step();
    for (int i = 0; i < 33; i++) begin
      setin(2'b01, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 3'd0);
      if (i == 31) chk("ret32_valid", return_valid, 1);
      if (i == 32) chk("ret33_invalid", return_valid, 0);
      step();
    end

    // Checkpoint {3,3,0x50}, mispredict, repair.
    setin(2'b01, 2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 2'd0, 1'b0, 3'd0); step();
    setin(2'b01, 2'b01, 2'b00, 2'b00, 32'h20, 32'h0, 2'd0, 1'b0, 3'd0); step();
    setin(2'b01, 2'b01, 2'b00, 2'b00, 32'h4C, 32'h0, 2'd0, 1'b0, 3'd0); step();
    setin(2'b11, 2'b10, 2'b00, 2'b01, 32'h1F0, 32'h200, 2'd0, 1'b0, 3'd0);
    chk("br_tag0", ckpt_tag[0], 0); chk("brcall_idx", ras_wr_idx, 3); chk("brcall_data", ras_wr_data, 32'h204);
    step();
    setin(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 3'd0);
    chk("misp_stall", fetch_stall, 1);
    step();
    idle(2'd0);
    chk("rec_stall", fetch_stall, 1); chk("rec_wr_en", ras_wr_en, 1);
    chk("rec_wr_idx", ras_wr_idx, 2); chk("rec_wr_data", ras_wr_data, 32'h50); chk("rec_ptr3", ras_rd_idx, 2);
    step();
    idle(2'd1); chk("post_rec_stall", fetch_stall, 0); step();

    // Checkpoint table full, retire frees tag 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      setin(2'b11, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 3'd0);
      chk("fill_tag0", ckpt_tag[0], 2 * i); chk("fill_tag1", ckpt_tag[1], 2 * i + 1);
      step();
    end
    setin(2'b01, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 2'd1, 1'b0, 3'd0);
    chk("full_stall", fetch_stall, 1);
    step();
    setin(2'b01, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 2'd0, 1'b0, 3'd0);
    chk("reuse_stall", fetch_stall, 0); chk("reuse_tag0", ckpt_tag[0], 0);
    step();

    // Return in slot0 shadows call in slot1.
    setin(2'b11, 2'b10, 2'b01, 2'b00, 32'h0, 32'h500, 2'd0, 1'b0, 3'd0);
    chk("shadow_wr_en", ras_wr_en, 0);
    step();
    idle(2'd0); chk("shadow_ptr", ras_rd_idx, 30); step();

    // Mispredict with concurrent retire, then re-mispredict in RECOVER.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      setin(2'b11, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 2'd0, 1'b0, 3'd0); step();
    end
    setin(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'd2, 1'b1, 3'd2); step();
    setin(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 3'd2);
    chk("remisp_stall", fetch_stall, 1); chk("remisp_no_wr", ras_wr_en, 0);
    step();
    idle(2'd0); chk("rec2_stall", fetch_stall, 1); step();
    setin(2'b01, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 2'd0, 1'b0, 3'd0);
    chk("trunc_tag3", ckpt_tag[0], 3);
    step();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin do_reset(); continue; end
      v = 0; c = 0; r = 0; b = 0;
      for (int s = 0; s < 2; s++) begin
        k = $urandom_range(0, 5);
        v[s] = (k != 0); c[s] = (k == 2); r[s] = (k == 3); b[s] = (k >= 4);
      end
      rmax = (m_used < 2) ? m_used : 2;
      ret = 2'($urandom_range(0, rmax));
      mis = (m_used > 0) && ($urandom_range(0, 9) == 0);
      tag = 3'd0;
      if (mis) begin
        off = $urandom_range(0, m_used - 1);
        tag = 3'((m_head + off) % 8);
        if (int'(ret) > off) ret = 2'(off);
      end
      setin(v, c, r, b, $urandom, $urandom, ret, mis, tag);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ras_ckpt_ctrl.md
Name: ras_ckpt_ctrl

Overview:
- Speculative controller for the return address stack.
- Owns the stack pointer and the occupancy count. Drives the write/read ports of an external stack array from 2-wide fetch call/return hints.
- Checkpoints the pointer, count and top-of-stack value for every conditional branch. On mispredict it restores that state and repairs the top entry.
- Sits between fetch/decode and the stack array; retire and the branch unit feed it.

Parameters:
- STACK_SIZE, 32, stack entries (power of 2); PTR_W = $clog2(STACK_SIZE).
- CKPT_DEPTH, 8, checkpoint entries (power of 2); TAG_W = $clog2(CKPT_DEPTH).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  2  slot valid, [0] older
- fetch_call  in  2  slot is a call
- fetch_return  in  2  slot is a return
- fetch_branch  in  2  slot is a conditional branch (needs checkpoint)
- fetch_PC  in  2x`XLEN  slot PCs
- fetch_stall  out  1  bundle not accepted this cycle
- ckpt_tag  out  2xTAG_W  tag assigned to each branch slot
- ras_rd_idx  out  PTR_W  ptr-1 (top entry)
- ras_rd_data  in  `XLEN  stack[ras_rd_idx], combinational
- ras_wr_en  out  1  stack write strobe
- ras_wr_idx  out  PTR_W  write index
- ras_wr_data  out  `XLEN  write data
- return_valid  out  1  a processed slot is a return and count>0
- return_target  out  `XLEN  predicted return PC
- retire_cnt  in  2  number of oldest checkpoints freed (0-2)
- mispredict  in  1  branch recovery request
- mispredict_tag  in  TAG_W  checkpoint to restore

Behaviour:
- Reset (async): ptr=0, count=0, ckpt head=tail=used=0, state=NORMAL. All outputs 0; ras_rd_idx = STACK_SIZE-1.
- Slot processing order:
  - Slot0 is processed if valid.
  - Slot1 is processed only if valid and slot0 is not a valid call or return (a control transfer ends the bundle).
- Call: ras_wr_en=1, ras_wr_idx=ptr, ras_wr_data=PC+4 (mod 2^XLEN); ptr<=ptr+1 (wraps); count<=min(count+1, STACK_SIZE).
- Return:
  - return_target=ras_rd_data; return_valid=(count!=0).
  - ptr<=ptr-1 (wraps); count<=max(count-1, 0).
  - Pointer moves even when count=0.
- Checkpoint allocation:
  - Each processed branch slot gets entry at tail (slot0 first) storing {ptr, count, ras_rd_data}: the pre-cycle state, which is valid because branch slots precede any call/return in the bundle.
  - ckpt_tag = allocated index.
- Stall: fetch_stall=1 when any of the following holds; a stalled cycle causes no ptr/count/table change and no wr_en.
  - branches needing allocation > CKPT_DEPTH - used (retire this cycle not counted);
  - state=RECOVER;
  - mispredict=1.
- Retire: head<=head+retire_cnt, used-=retire_cnt; concurrent with allocation and mispredict. retire_cnt > used is illegal (assertion).
- Mispredict (NORMAL or RECOVER):
  - Restore ptr, count from entry[mispredict_tag].
  - tail<=tag+1; used recomputed from head/tail after retire.
  - Latch saved top value; state<=RECOVER.
- RECOVER, one cycle:
  - If restored count!=0: ras_wr_en=1, ras_wr_idx=ptr-1, ras_wr_data=saved top.
  - state<=NORMAL.
  - A new mispredict in RECOVER wins and re-enters RECOVER with the new entry.
- Latency: all outputs are combinational from current state and inputs; state updates at the next edge.
- Reset mid-recovery aborts immediately to the reset state.

Decomposition:
- Shared package: RAS_PTR_W and RAS_TAG_W constants; ras_ckpt_t struct {ptr, count, top}; ctrl_state_e enum {NORMAL, RECOVER}.
- Sub-module ras_ckpt_fifo: circular checkpoint table with alloc(2)/retire(2)/truncate-to-tag, exposing used and a read port.

Test Plan:
- Reset, then slot0 call with PC=0x100 → wr idx 0 data 0x104, ptr=1; next cycle slot0 return with rd_data=0x104 → return_valid=1, target=0x104, ptr=0.
- 33 calls with STACK_SIZE=32 → ptr wraps to 1, count stays 32; 33 returns → last return_valid=0, count=0.
- Slot0 branch, slot1 call at PC=0x200 (ptr=3, top=0x50) → tag 0 saves {3, 3, 0x50}, wr idx 3=0x204. Then mispredict tag 0 → next cycle ptr=3, fetch_stall=1, wr idx 2 data 0x50, then NORMAL.
- 8 branches allocated, none retired → 9th branch cycle fetch_stall=1 with no state change; same cycle retire_cnt=1 → following cycle accepted, tag 0 reused.
- Slot0 return and slot1 call both valid → only the return is processed; no write; ptr-1.
- Mispredict tag 2 with tags 0-5 live and retire_cnt=2 same cycle → head=2, tail=3, used=1; second mispredict during RECOVER to tag 2 → RECOVER repeats.
